// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage integer pipe: a destination-register scoreboard for EX/MEM/WB
// plus the issue/stall/bubble/flush decode for the ID stage and a saturating stall counter.
module hazard_ctrl #(
    parameter int RegAddrWidth = 5,
    parameter int Depth        = 3,
    parameter int CntWidth     = 16
) (
    input  logic                    iClk,
    input  logic                    nRst,
    input  logic                    iEn,
    input  logic                    iIdValid,
    input  logic                    iRs1En,
    input  logic                    iRs2En,
    input  logic [RegAddrWidth-1:0] iRs1Addr,
    input  logic [RegAddrWidth-1:0] iRs2Addr,
    input  logic                    iRdEn,
    input  logic [RegAddrWidth-1:0] iRdAddr,
    input  logic                    iBrTrue,
    input  logic                    iJump,
    input  logic                    iMemBusy,
    output logic                    oStallIF,
    output logic                    oStallID,
    output logic                    oBubbleEX,
    output logic                    oFlushIF,
    output logic [CntWidth-1:0]     oStallCnt
);

    // Slot 0 = EX, slot Depth-1 = WB.
    logic [Depth-1:0]        slot_valid;
    logic [RegAddrWidth-1:0] slot_rd [Depth];

    logic rs1_hit;
    logic rs2_hit;
    logic match;
    logic advance;
    logic issue;

    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int k = 0; k < Depth; k++) begin
            if (slot_valid[k] && (slot_rd[k] == iRs1Addr)) rs1_hit = 1'b1;
            if (slot_valid[k] && (slot_rd[k] == iRs2Addr)) rs2_hit = 1'b1;
        end
    end

    // x0 is hardwired to zero, so it can never carry a dependence.
    assign match = iIdValid &
                   ((iRs1En & (iRs1Addr != '0) & rs1_hit) |
                    (iRs2En & (iRs2Addr != '0) & rs2_hit));

    assign advance = iEn & ~iMemBusy;
    assign issue   = advance & iIdValid & ~match;

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            slot_valid <= '0;
            for (int k = 0; k < Depth; k++) slot_rd[k] <= '0;
        end else if (advance) begin
            for (int k = Depth - 1; k > 0; k--) begin
                slot_valid[k] <= slot_valid[k-1];
                slot_rd[k]    <= slot_rd[k-1];
            end
            if (issue) begin
                slot_valid[0] <= iRdEn & (iRdAddr != '0);
                slot_rd[0]    <= iRdAddr;
            end else begin
                slot_valid[0] <= 1'b0;
                slot_rd[0]    <= '0;
            end
        end
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            oStallCnt <= '0;
        end else if (advance && match && !(&oStallCnt)) begin
            oStallCnt <= oStallCnt + CntWidth'(1);
        end
    end

    // A stalled branch is not allowed to flush: its compare used stale operands.
    always_comb begin
        oStallIF  = 1'b0;
        oStallID  = 1'b0;
        oBubbleEX = 1'b0;
        oFlushIF  = 1'b0;
        if (!nRst) begin
            oStallIF  = 1'b0;
        end else if (!iEn || iMemBusy) begin
            oStallIF  = 1'b1;
            oStallID  = 1'b1;
        end else if (match) begin
            oStallIF  = 1'b1;
            oStallID  = 1'b1;
            oBubbleEX = 1'b1;
        end else begin
            oBubbleEX = ~iIdValid;
            oFlushIF  = iIdValid & (iBrTrue | iJump);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a per-cycle vector table plus hand sequences for
// counter saturation (4-bit instance) and reset in the middle of a hazard.
module tb_hazard_ctrl;

    typedef struct {
        logic       en, idv, r1e;
        logic [4:0] r1;
        logic       r2e;
        logic [4:0] r2;
        logic       rde;
        logic [4:0] rd;
        logic       br, jmp, busy;
        logic       st, bub, fl;
        logic [15:0] cnt;
    } vec_t;

    logic iClk = 1'b0;
    logic nRst;
    logic iEn, iIdValid, iRs1En, iRs2En, iRdEn, iBrTrue, iJump, iMemBusy;
    logic [4:0] iRs1Addr, iRs2Addr, iRdAddr;
    logic oStallIF, oStallID, oBubbleEX, oFlushIF;
    logic [15:0] oStallCnt;
    logic s_stall_if, s_stall_id, s_bubble_ex, s_flush_if;
    logic [3:0] s_stall_cnt;

    int n_vec  = 0;
    int n_fail = 0;
    vec_t vecs[$];

    always #5 iClk = ~iClk;

    hazard_ctrl #(.RegAddrWidth(5), .Depth(3), .CntWidth(16)) dut (
        .iClk(iClk), .nRst(nRst), .iEn(iEn), .iIdValid(iIdValid),
        .iRs1En(iRs1En), .iRs2En(iRs2En), .iRs1Addr(iRs1Addr), .iRs2Addr(iRs2Addr),
        .iRdEn(iRdEn), .iRdAddr(iRdAddr), .iBrTrue(iBrTrue), .iJump(iJump),
        .iMemBusy(iMemBusy), .oStallIF(oStallIF), .oStallID(oStallID),
        .oBubbleEX(oBubbleEX), .oFlushIF(oFlushIF), .oStallCnt(oStallCnt)
    );

    hazard_ctrl #(.RegAddrWidth(5), .Depth(3), .CntWidth(4)) dut_sat (
        .iClk(iClk), .nRst(nRst), .iEn(iEn), .iIdValid(iIdValid),
        .iRs1En(iRs1En), .iRs2En(iRs2En), .iRs1Addr(iRs1Addr), .iRs2Addr(iRs2Addr),
        .iRdEn(iRdEn), .iRdAddr(iRdAddr), .iBrTrue(iBrTrue), .iJump(iJump),
        .iMemBusy(iMemBusy), .oStallIF(s_stall_if), .oStallID(s_stall_id),
        .oBubbleEX(s_bubble_ex), .oFlushIF(s_flush_if), .oStallCnt(s_stall_cnt)
    );

    function automatic vec_t mk(logic en, logic idv, logic r1e, logic [4:0] r1,
                                logic r2e, logic [4:0] r2, logic rde, logic [4:0] rd,
                                logic br, logic jmp, logic busy,
                                logic st, logic bub, logic fl, logic [15:0] cnt);
        vec_t v;
        v.en = en; v.idv = idv; v.r1e = r1e; v.r1 = r1; v.r2e = r2e; v.r2 = r2;
        v.rde = rde; v.rd = rd; v.br = br; v.jmp = jmp; v.busy = busy;
        v.st = st; v.bub = bub; v.fl = fl; v.cnt = cnt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        iEn = v.en; iIdValid = v.idv; iRs1En = v.r1e; iRs1Addr = v.r1;
        iRs2En = v.r2e; iRs2Addr = v.r2; iRdEn = v.rde; iRdAddr = v.rd;
        iBrTrue = v.br; iJump = v.jmp; iMemBusy = v.busy;
    endtask

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx, input logic st, input logic bub,
                             input logic fl, input logic [15:0] cnt, input logic [3:0] scnt);
        chk({tag, "_stall_if"},  idx, 16'(oStallIF),  16'(st));
        chk({tag, "_stall_id"},  idx, 16'(oStallID),  16'(st));
        chk({tag, "_bubble_ex"}, idx, 16'(oBubbleEX), 16'(bub));
        chk({tag, "_flush_if"},  idx, 16'(oFlushIF),  16'(fl));
        chk({tag, "_stall_cnt"}, idx, oStallCnt, cnt);
        chk({tag, "_sat_cnt"},   idx, 16'(s_stall_cnt), 16'(scnt));
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    initial begin
        int exp_cnt;
        vec_t v;

        // Back-to-back RAW on x5.
        vecs.push_back(mk(1,1,1,5'd1,1,5'd2,1,5'd5,0,0,0, 0,0,0,0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1,1,1,5'd5,1,5'd1,1,5'd6,0,0,0, 1,1,0,16'(i)));
        vecs.push_back(mk(1,1,1,5'd5,1,5'd1,1,5'd6,0,0,0, 0,0,0,3));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,1,0,3));
        // Distance 3 on x7, then rd=x0 producer and x0 reader.
        vecs.push_back(mk(1,1,0,0,0,0,1,5'd7,0,0,0, 0,0,0,3));
        vecs.push_back(mk(1,1,1,5'd1,1,5'd2,1,5'd8,0,0,0, 0,0,0,3));
        vecs.push_back(mk(1,1,1,5'd1,1,5'd2,1,5'd9,0,0,0, 0,0,0,3));
        vecs.push_back(mk(1,1,1,5'd7,0,0,1,5'd10,0,0,0, 1,1,0,3));
        vecs.push_back(mk(1,1,1,5'd7,0,0,1,5'd10,0,0,0, 0,0,0,4));
        vecs.push_back(mk(1,1,1,5'd3,0,0,1,5'd0,0,0,0, 0,0,0,4));
        vecs.push_back(mk(1,1,1,5'd0,1,5'd0,0,0,0,0,0, 0,0,0,4));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,1,0,4));
        // Hazard-free taken branch, then a jump linking x1.
        vecs.push_back(mk(1,1,1,5'd1,1,5'd2,0,0,1,0,0, 0,0,1,4));
        vecs.push_back(mk(1,1,0,0,0,0,1,5'd1,0,1,0, 0,0,1,4));
        // Branch dependent on producer x11 one cycle ahead.
        vecs.push_back(mk(1,1,1,5'd2,0,0,1,5'd11,0,0,0, 0,0,0,4));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1,1,1,5'd11,1,5'd2,0,0,1,0,0, 1,1,0,16'(4+i)));
        vecs.push_back(mk(1,1,1,5'd11,1,5'd2,0,0,1,0,0, 0,0,1,7));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,1,0,7));
        // MEM freeze during a pending hazard on x12.
        vecs.push_back(mk(1,1,0,0,0,0,1,5'd12,0,0,0, 0,0,0,7));
        vecs.push_back(mk(1,1,0,0,1,5'd12,0,0,0,0,0, 1,1,0,7));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1,1,0,0,1,5'd12,0,0,0,0,1, 1,0,0,8));
        vecs.push_back(mk(1,1,0,0,1,5'd12,0,0,0,0,0, 1,1,0,8));
        vecs.push_back(mk(1,1,0,0,1,5'd12,0,0,0,0,0, 1,1,0,9));
        vecs.push_back(mk(1,1,0,0,1,5'd12,0,0,0,0,0, 0,0,0,10));
        // Pipeline disabled with a taken branch in ID.
        vecs.push_back(mk(0,1,1,5'd1,0,0,0,0,1,0,0, 1,0,0,10));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,1,0,10));

        nRst = 1'b0;
        drive(mk(1,1,1,5'd1,0,0,0,0,1,1,0, 0,0,0,0));
        #12;
        check_all("reset", 0, 0, 0, 0, 0, 0);
        nRst = 1'b1;
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #2;
            check_all("vec", i, vecs[i].st, vecs[i].bub, vecs[i].fl, vecs[i].cnt, vecs[i].cnt[3:0]);
            step();
        end

        // Seven producer/reader pairs: 21 hazard cycles, 4-bit counter must stop at 15.
        exp_cnt = 10;
        for (int rep = 0; rep < 7; rep++) begin
            drive(mk(1,1,0,0,0,0,1,5'd13,0,0,0, 0,0,0,0));
            #2;
            check_all("sat_prod", rep, 0, 0, 0, 16'(exp_cnt), (exp_cnt > 15) ? 4'd15 : 4'(exp_cnt));
            step();
            for (int s = 0; s < 4; s++) begin
                drive(mk(1,1,1,5'd13,0,0,0,0,0,0,0, 0,0,0,0));
                #2;
                if (s < 3)
                    check_all("sat_stall", rep*4+s, 1, 1, 0, 16'(exp_cnt), (exp_cnt > 15) ? 4'd15 : 4'(exp_cnt));
                else
                    check_all("sat_issue", rep, 0, 0, 0, 16'(exp_cnt), (exp_cnt > 15) ? 4'd15 : 4'(exp_cnt));
                step();
                if (s < 3) exp_cnt++;
            end
        end

        // Fill EX/MEM/WB with x22/x21/x20, then reset while a reader of x20 stalls.
        for (int r = 20; r < 23; r++) begin
            drive(mk(1,1,0,0,0,0,1,5'(r),0,0,0, 0,0,0,0));
            step();
        end
        v = mk(1,1,1,5'd20,0,0,0,0,1,0,0, 0,0,0,0);
        drive(v);
        #2;
        check_all("pre_reset", 0, 1, 1, 0, 16'(exp_cnt), 4'd15);
        nRst = 1'b0;
        #1;
        check_all("in_reset", 0, 0, 0, 0, 0, 0);
        step();
        check_all("in_reset", 1, 0, 0, 0, 0, 0);
        nRst = 1'b1;
        #1;
        check_all("post_reset", 0, 0, 0, 1, 0, 0);
        step();
        drive(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
        #1;
        check_all("post_reset", 1, 0, 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
